// File: rtl/vector_cache_pkg.sv
// Shared types and defaults for the vector cache lane datapath.
package vector_cache_pkg;

  localparam int unsigned VC_BEATS   = 4;
  localparam int unsigned VC_LANE_DW = 32;

  typedef struct packed {
    logic [7:0] index;
    logic [1:0] way;
  } arb_out_req_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_TURN     = 2'd3
  } issue_state_e;

endpackage

// File: rtl/vc_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; ready is held low until the first edge after reset.
module vc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             push_rdy_o,
  output logic             not_empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wptr_q, rptr_q;
  logic             rdy_en_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full;
  logic             push_fire, pop_fire;

  assign full        = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push_rdy_o  = rdy_en_q & ~full;
  assign not_empty_o = (wptr_q != rptr_q);
  assign head_o      = mem_q[rptr_q[PW-1:0]];
  assign push_fire   = push_i & push_rdy_o;
  assign pop_fire    = pop_i & not_empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      if (push_fire) wptr_q <= wptr_q + (PW+1)'(1);
      if (pop_fire)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_fire) mem_q[wptr_q[PW-1:0]] <= data_i;
  end

endmodule

// File: rtl/mem_lane_cmd_issuer.sv
// Per-lane issuer: queues read/write requests and expands each into BEATS SRAM command beats.
module mem_lane_cmd_issuer
  import vector_cache_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BEATS      = VC_BEATS,
  parameter int unsigned DW         = VC_LANE_DW
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_req_vld,
  output logic                       rd_req_rdy,
  input  arb_out_req_t               rd_req_pld,
  input  logic                       wr_req_vld,
  output logic                       wr_req_rdy,
  input  arb_out_req_t               wr_req_pld,
  input  logic [BEATS*DW-1:0]        wr_req_data,
  output logic                       read_cmd_vld,
  output arb_out_req_t               read_cmd_pld,
  output logic                       write_cmd_vld,
  output arb_out_req_t               write_cmd_pld,
  output logic [$clog2(BEATS)-1:0]   cmd_beat,
  output logic                       wr_data_vld,
  output logic [DW-1:0]              wr_data,
  output logic                       busy
);

  localparam int unsigned BW     = $clog2(BEATS);
  localparam int unsigned LINE_W = BEATS * DW;
  localparam int unsigned PLD_W  = $bits(arb_out_req_t);

  logic                    rd_ne, wr_ne, rd_pop, wr_pop;
  arb_out_req_t            rd_head_pld;
  logic [LINE_W+PLD_W-1:0] wr_head;

  vc_sync_fifo #(.WIDTH(PLD_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (rd_req_vld),
    .data_i      (rd_req_pld),
    .pop_i       (rd_pop),
    .push_rdy_o  (rd_req_rdy),
    .not_empty_o (rd_ne),
    .head_o      (rd_head_pld)
  );

  vc_sync_fifo #(.WIDTH(LINE_W + PLD_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (wr_req_vld),
    .data_i      ({wr_req_data, wr_req_pld}),
    .pop_i       (wr_pop),
    .push_rdy_o  (wr_req_rdy),
    .not_empty_o (wr_ne),
    .head_o      (wr_head)
  );

  issue_state_e      state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic              last_rd_q, last_rd_d;
  arb_out_req_t      cur_pld_q, cur_pld_d;
  logic [LINE_W-1:0] cur_data_q, cur_data_d;
  logic              pick_rd, burst_end, start_rd, start_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      last_rd_q  <= 1'b0;
      cur_pld_q  <= '0;
      cur_data_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      last_rd_q  <= last_rd_d;
      cur_pld_q  <= cur_pld_d;
      cur_data_q <= cur_data_d;
    end
  end

  // Arbitration favours the type not served last; bursts only yield at their final beat.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    last_rd_d  = last_rd_q;
    cur_pld_d  = cur_pld_q;
    cur_data_d = cur_data_q;
    rd_pop     = 1'b0;
    wr_pop     = 1'b0;
    start_rd   = 1'b0;
    start_wr   = 1'b0;
    pick_rd    = rd_ne && (!wr_ne || !last_rd_q);
    burst_end  = (beat_q == BW'(BEATS - 1));

    unique case (state_q)
      ST_IDLE: begin
        if (pick_rd)    start_rd = 1'b1;
        else if (wr_ne) start_wr = 1'b1;
      end
      ST_RD_BURST: begin
        beat_d = beat_q + BW'(1);
        if (burst_end) begin
          if (pick_rd)    start_rd = 1'b1;
          else if (wr_ne) state_d  = ST_TURN;
          else            state_d  = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        beat_d = beat_q + BW'(1);
        if (burst_end) begin
          if (pick_rd)    state_d  = ST_TURN;
          else if (wr_ne) start_wr = 1'b1;
          else            state_d  = ST_IDLE;
        end
      end
      ST_TURN: begin
        if (last_rd_q) start_wr = 1'b1;
        else           start_rd = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_rd) begin
      rd_pop    = 1'b1;
      state_d   = ST_RD_BURST;
      beat_d    = '0;
      last_rd_d = 1'b1;
      cur_pld_d = rd_head_pld;
    end
    if (start_wr) begin
      wr_pop     = 1'b1;
      state_d    = ST_WR_BURST;
      beat_d     = '0;
      last_rd_d  = 1'b0;
      cur_pld_d  = arb_out_req_t'(wr_head[PLD_W-1:0]);
      cur_data_d = wr_head[PLD_W +: LINE_W];
    end
  end

  logic              read_cmd_vld_q, write_cmd_vld_q, busy_q;
  arb_out_req_t      read_cmd_pld_q, write_cmd_pld_q;
  logic [BW-1:0]     cmd_beat_q;
  logic [DW-1:0]     wr_data_q;
  logic [LINE_W-1:0] data_shifted;

  assign data_shifted = cur_data_q >> (32'(beat_q) * DW);

  // Output stage: one register behind the FSM, so the first beat lands two cycles after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_cmd_vld_q  <= 1'b0;
      write_cmd_vld_q <= 1'b0;
      read_cmd_pld_q  <= '0;
      write_cmd_pld_q <= '0;
      cmd_beat_q      <= '0;
      wr_data_q       <= '0;
      busy_q          <= 1'b0;
    end else begin
      read_cmd_vld_q  <= (state_q == ST_RD_BURST);
      write_cmd_vld_q <= (state_q == ST_WR_BURST);
      cmd_beat_q      <= (state_q == ST_RD_BURST || state_q == ST_WR_BURST) ? beat_q : '0;
      busy_q          <= (state_q != ST_IDLE) || rd_ne || wr_ne;
      if (state_q == ST_RD_BURST) read_cmd_pld_q <= cur_pld_q;
      if (state_q == ST_WR_BURST) begin
        write_cmd_pld_q <= cur_pld_q;
        wr_data_q       <= DW'(data_shifted);
      end
    end
  end

  assign read_cmd_vld  = read_cmd_vld_q;
  assign read_cmd_pld  = read_cmd_pld_q;
  assign write_cmd_vld = write_cmd_vld_q;
  assign write_cmd_pld = write_cmd_pld_q;
  assign cmd_beat      = cmd_beat_q;
  assign wr_data_vld   = write_cmd_vld_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_lane_cmd_issuer.sv
// Directed bench for mem_lane_cmd_issuer: vector table plus multi-cycle corner sequences.
module tb_mem_lane_cmd_issuer;
  import vector_cache_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               rd_req_vld = 1'b0, wr_req_vld = 1'b0;
  logic               rd_req_rdy, wr_req_rdy;
  arb_out_req_t       rd_req_pld = '0, wr_req_pld = '0;
  logic [127:0]       wr_req_data = '0;
  logic               read_cmd_vld, write_cmd_vld, wr_data_vld, busy;
  arb_out_req_t       read_cmd_pld, write_cmd_pld;
  logic [1:0]         cmd_beat;
  logic [31:0]        wr_data;

  int checks = 0;
  int errors = 0;

  mem_lane_cmd_issuer dut (
    .clk(clk), .rst_n(rst_n),
    .rd_req_vld(rd_req_vld), .rd_req_rdy(rd_req_rdy), .rd_req_pld(rd_req_pld),
    .wr_req_vld(wr_req_vld), .wr_req_rdy(wr_req_rdy), .wr_req_pld(wr_req_pld),
    .wr_req_data(wr_req_data),
    .read_cmd_vld(read_cmd_vld), .read_cmd_pld(read_cmd_pld),
    .write_cmd_vld(write_cmd_vld), .write_cmd_pld(write_cmd_pld),
    .cmd_beat(cmd_beat), .wr_data_vld(wr_data_vld), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && read_cmd_vld && write_cmd_vld) begin
      errors++;
      $display("FAIL vld_overlap at %0t: read_cmd_vld and write_cmd_vld both 1", $time);
    end
  end

  typedef struct {
    logic         rd_vld, wr_vld, wd_vld, busy, rd_rdy, wr_rdy;
    logic [1:0]   beat;
    arb_out_req_t rpld, wpld;
    logic [31:0]  wdata;
  } smp_t;

  smp_t log_q[$];

  typedef struct {
    logic             do_rd, do_wr;
    arb_out_req_t     rpld, wpld;
    logic [3:0][31:0] words;
    int               rd_first, wr_first;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    smp_t s;
    @(posedge clk);
    #1;
    s.rd_vld = read_cmd_vld;  s.wr_vld = write_cmd_vld; s.wd_vld = wr_data_vld;
    s.busy   = busy;          s.rd_rdy = rd_req_rdy;    s.wr_rdy = wr_req_rdy;
    s.beat   = cmd_beat;      s.rpld   = read_cmd_pld;  s.wpld   = write_cmd_pld;
    s.wdata  = wr_data;
    log_q.push_back(s);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rd_req_vld = 1'b0;
    wr_req_vld = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rdy_after_release", 64'({rd_req_rdy, wr_req_rdy}), 64'(2'b11));
    log_q.delete();
  endtask

  task automatic check_beat(input string tag, input int idx, input logic is_wr, input int beat,
                            input arb_out_req_t pld, input logic [31:0] word);
    smp_t s;
    s = log_q[idx];
    chk({tag, "_rd_vld"}, 64'(s.rd_vld), 64'(!is_wr));
    chk({tag, "_wr_vld"}, 64'(s.wr_vld), 64'(is_wr));
    chk({tag, "_beat"}, 64'(s.beat), 64'(beat));
    if (is_wr) begin
      chk({tag, "_wpld"}, 64'(s.wpld), 64'(pld));
      chk({tag, "_wdata"}, 64'(s.wdata), 64'(word));
      chk({tag, "_wd_vld"}, 64'(s.wd_vld), 64'(1'b1));
    end else begin
      chk({tag, "_rpld"}, 64'(s.rpld), 64'(pld));
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, '{8'h12, 2'd3}, '{8'h00, 2'd0},
                {32'h0, 32'h0, 32'h0, 32'h0}, 2, 99};
    vecs[1] = '{1'b0, 1'b1, '{8'h00, 2'd0}, '{8'h45, 2'd1},
                {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 99, 2};
    vecs[2] = '{1'b1, 1'b1, '{8'h07, 2'd0}, '{8'h08, 2'd2},
                {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 2, 7};
    vecs[3] = '{1'b0, 1'b1, '{8'h00, 2'd0}, '{8'hFF, 2'd3},
                {32'hCAFE_F00D, 32'h0BAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF}, 99, 2};

    // Reset state while rst_n is held low
    #12;
    chk("reset_vlds", 64'({read_cmd_vld, write_cmd_vld, wr_data_vld, busy}), 64'(0));
    chk("reset_rdys", 64'({rd_req_rdy, wr_req_rdy}), 64'(0));
    chk("reset_data", 64'({read_cmd_pld, write_cmd_pld, cmd_beat, wr_data}), 64'(0));

    // Table: single transactions, accepted on the first logged edge
    for (int v = 0; v < 4; v++) begin
      do_reset();
      rd_req_vld  = vecs[v].do_rd;
      rd_req_pld  = vecs[v].rpld;
      wr_req_vld  = vecs[v].do_wr;
      wr_req_pld  = vecs[v].wpld;
      wr_req_data = vecs[v].words;
      step();
      rd_req_vld = 1'b0;
      wr_req_vld = 1'b0;
      repeat (12) step();
      for (int k = 0; k < 13; k++) begin
        logic exp_rd, exp_wr;
        exp_rd = vecs[v].do_rd && k >= vecs[v].rd_first && k < vecs[v].rd_first + 4;
        exp_wr = vecs[v].do_wr && k >= vecs[v].wr_first && k < vecs[v].wr_first + 4;
        if (exp_rd)
          check_beat($sformatf("v%0d_c%0d", v, k), k, 1'b0, k - vecs[v].rd_first,
                     vecs[v].rpld, 32'h0);
        else if (exp_wr)
          check_beat($sformatf("v%0d_c%0d", v, k), k, 1'b1, k - vecs[v].wr_first,
                     vecs[v].wpld, vecs[v].words[k - vecs[v].wr_first]);
        else
          chk($sformatf("v%0d_c%0d_idle", v, k),
              64'({log_q[k].rd_vld, log_q[k].wr_vld, log_q[k].wd_vld}), 64'(0));
      end
      chk($sformatf("v%0d_busy_end", v), 64'(log_q[12].busy), 64'(0));
    end

    // Five back-to-back reads into a depth-4 queue: 20 beats, no bubble
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("b2b_rdy_before_push%0d", i), 64'(rd_req_rdy), 64'(1));
      rd_req_vld = 1'b1;
      rd_req_pld = '{8'h50 + 8'(i), 2'(i)};
      step();
    end
    rd_req_vld = 1'b0;
    chk("b2b_rdy_full", 64'(log_q[4].rd_rdy), 64'(0));
    repeat (20) step();
    for (int j = 0; j < 20; j++)
      check_beat($sformatf("b2b_%0d", j), 2 + j, 1'b0, j % 4,
                 '{8'h50 + 8'(j / 4), 2'(j / 4)}, 32'h0);
    chk("b2b_tail_idle", 64'({log_q[22].rd_vld, log_q[22].wr_vld}), 64'(0));

    // Alternating load: R,W,R,W,R,W with one turnaround cycle between bursts
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rd_req_vld = 1'b1;
      rd_req_pld = '{8'h20 + 8'(i), 2'd1};
      wr_req_vld = 1'b1;
      wr_req_pld = '{8'h30 + 8'(i), 2'd2};
      for (int k = 0; k < 4; k++) wr_req_data[k*32 +: 32] = 32'hB000_0000 + 32'(i * 16 + k);
      step();
    end
    rd_req_vld = 1'b0;
    wr_req_vld = 1'b0;
    repeat (31) step();
    for (int b = 0; b < 6; b++) begin
      int j;
      j = b / 2;
      for (int k = 0; k < 4; k++) begin
        if (b % 2 == 0)
          check_beat($sformatf("alt_b%0d_k%0d", b, k), 2 + 5*b + k, 1'b0, k,
                     '{8'h20 + 8'(j), 2'd1}, 32'h0);
        else
          check_beat($sformatf("alt_b%0d_k%0d", b, k), 2 + 5*b + k, 1'b1, k,
                     '{8'h30 + 8'(j), 2'd2}, 32'hB000_0000 + 32'(j * 16 + k));
      end
      if (b < 5)
        chk($sformatf("alt_turn%0d", b),
            64'({log_q[6 + 5*b].rd_vld, log_q[6 + 5*b].wr_vld}), 64'(0));
    end
    chk("alt_busy_mid", 64'(log_q[10].busy), 64'(1));
    chk("alt_busy_end", 64'(log_q[32].busy), 64'(0));

    // Reset asserted during beat 2 of a write burst
    do_reset();
    wr_req_vld  = 1'b1;
    wr_req_pld  = '{8'h77, 2'd0};
    wr_req_data = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    step();
    wr_req_vld = 1'b0;
    repeat (4) step();
    check_beat("mid_pre", 4, 1'b1, 2, '{8'h77, 2'd0}, 32'hD2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vlds", 64'({read_cmd_vld, write_cmd_vld, wr_data_vld, busy}), 64'(0));
    chk("mid_rst_data", 64'({cmd_beat, wr_data}), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    log_q.delete();
    repeat (6) step();
    for (int k = 0; k < 6; k++)
      chk($sformatf("mid_after_%0d", k),
          64'({log_q[k].rd_vld, log_q[k].wr_vld, log_q[k].wd_vld, log_q[k].busy, log_q[k].beat}),
          64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
